instr_fetch: RTL and testbench

Fetch stage sitting directly upstream of the instruction memory and downstream into decode. Generates the program counter, presents the fetch address to the synchronous-read instruction memory, captures the returned word together with its PC into a small fetch buffer, and hands instructions to decode over a valid/ready handshake. Handles control-flow redirects from execute by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_buf.sv | 57 +++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
// Pure declarations: no logic, no latency or backpressure of its own.
// Fetch-side FSM encoding, instruction size and default buffer entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_FULL = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally.
// Latency: a push is visible at the head in the cycle after it is written.
// Backpressure: the producer must not push into a full buffer unless it pops in the same cycle.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 push_dat,
    output entry_t                 head_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign do_push  = push & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(do_push && !do_pop && full));
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC generation, sync-read imem issue, fetch buffer to decode; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap.
// Latency: address issued in t, instruction valid to decode in t+2; redirect target valid in t+2.
// Backpressure: issue stalls while buffered + in-flight entries would exceed BUF_DEPTH, resuming on the popping cycle.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                       BUF_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr_out,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic                     fetch_misaligned
);

    localparam logic [1:0] S_RUN  = FS_RUN;
    localparam logic [1:0] S_FULL = FS_FULL;
    localparam logic [1:0] S_HALT = FS_HALT;
    localparam int         CW     = $clog2(BUF_DEPTH) + 2;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [1:0]                 state;
    logic [ADDRESS_WIDTH-1:0]   fetch_pc;
    logic [ADDRESS_WIDTH-1:0]   inflight_pc;
    logic [ADDRESS_WIDTH-1:0]   redirect_tgt;
    logic                       inflight;
    logic                       issue;
    logic                       room;
    logic                       pop;
    logic                       push;
    logic                       halted;
    logic                       redirect_bad;
    logic [$clog2(BUF_DEPTH):0] buf_count;
    logic                       buf_empty;
    logic [CW-1:0]              occ;
    entry_t                     head;
    entry_t                     push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign redirect_tgt     = redirect_pc;
    assign redirect_bad     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = misaligned_q;

    // Sticky until the next redirect, which either re-arms or clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)              misaligned_q <= 1'b0;
        else if (redirect_valid) misaligned_q <= redirect_bad;
    end
`else
    assign redirect_tgt     = redirect_pc & ~ADDRESS_WIDTH'(3);
    assign redirect_bad     = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    assign halted      = (state == S_HALT);
    assign instr_valid = rst_n & ~buf_empty;
    assign pop         = instr_valid & instr_ready;
    assign instr_out   = instr_valid ? head.instr : '0;
    assign pc_out      = instr_valid ? head.pc : '0;

    // Occupancy counts the slot a same-cycle pop frees, so issue resumes without a bubble.
    assign occ  = CW'(buf_count) + CW'(inflight) - CW'(pop);
    assign room = (occ < CW'(BUF_DEPTH));

    always_comb begin
        issue = 1'b0;
        if (redirect_valid) issue = ~redirect_bad;
        else if (!halted)   issue = room;
    end

    always_comb begin
        imem_addr = fetch_pc;
        if (!rst_n)              imem_addr = RESET_VECTOR;
        else if (redirect_valid) imem_addr = redirect_tgt;
    end

    // A redirect kills the response of the fetch issued before it.
    assign push             = inflight & ~redirect_valid;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_VECTOR;
            inflight_pc <= RESET_VECTOR;
            inflight    <= 1'b0;
            state       <= S_RUN;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + ADDRESS_WIDTH'(INSTR_BYTES);
            end
            if (redirect_bad) state <= S_HALT;
            else if (issue)   state <= S_RUN;
            else if (!halted) state <= S_FULL;
        end
    end

    fetch_buf #(
        .entry_t (entry_t),
        .DEPTH   (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_dat (push_entry),
        .head_dat (head),
        .empty    (buf_empty),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns word = address one cycle after the request.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;

    instr_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, drive this cycle's inputs, then let combinational outputs settle.
    task automatic cyc(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        rst_n          = rst;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    initial begin
        // Reset held for three cycles.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_misalign", 32'(fetch_misaligned), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Release at cycle r: reset vector issued in r, valid in r+2, then back-to-back.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("r0_addr", imem_addr, 32'h0);
        chk("r0_valid", 32'(instr_valid), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("r1_addr", imem_addr, 32'h4);
        chk("r1_valid", 32'(instr_valid), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk("stream_valid", 32'(instr_valid), 32'h1);
            chk("stream_pc", pc_out, 32'(4 * (k - 2)));
            chk("stream_instr", instr_out, 32'(4 * (k - 2)));
            chk("stream_addr", imem_addr, 32'(4 * k));
        end

        // Decode stall for six cycles: head 0x10, address frozen at 0x18.
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_pc", pc_out, 32'h10);
            chk("stall_addr", imem_addr, 32'h18);
        end
        exp_pc = 32'h10;
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk("release_valid", 32'(instr_valid), 32'h1);
            chk("release_pc", pc_out, exp_pc);
            chk("release_instr", instr_out, exp_pc);
            exp_pc = exp_pc + 32'h4;
        end

        // Fill the buffer (head 0x28), then redirect to 0x100.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("fill_pc", pc_out, 32'h28);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_pc", pc_out, 32'h28);
        cyc(1'b1, 1'b0, 1'b1, 32'h100);
        chk("redir_addr", imem_addr, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_t1_valid", 32'(instr_valid), 32'h0);
        chk("redir_t1_addr", imem_addr, 32'h104);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_t2_valid", 32'(instr_valid), 32'h1);
        chk("redir_t2_pc", pc_out, 32'h100);
        chk("redir_t2_instr", instr_out, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_t3_pc", pc_out, 32'h104);

        // Redirect while popping 0x108 and pushing the 0x10C response.
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        chk("rpp_valid", 32'(instr_valid), 32'h1);
        chk("rpp_pc", pc_out, 32'h108);
        chk("rpp_addr", imem_addr, 32'h200);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rpp_t1_valid", 32'(instr_valid), 32'h0);
        chk("rpp_t1_addr", imem_addr, 32'h204);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rpp_t2_pc", pc_out, 32'h200);
        chk("rpp_t2_instr", instr_out, 32'h200);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rpp_t3_pc", pc_out, 32'h204);

        // PC wrap at the top of the address space.
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc1", pc_out, 32'h0);
        chk("wrap_instr1", instr_out, 32'h0);

        // Misaligned redirect to 0x102.
        cyc(1'b1, 1'b1, 1'b1, 32'h102);
        chk("mis_flag_t0", 32'(fetch_misaligned), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_flag_t1", 32'(fetch_misaligned), 32'h1);
        chk("mis_valid_t1", 32'(instr_valid), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_valid_t2", 32'(instr_valid), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        chk("mis_flag_hold", 32'(fetch_misaligned), 32'h1);
        chk("mis_resume_addr", imem_addr, 32'h200);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_flag_clr", 32'(fetch_misaligned), 32'h0);
        chk("mis_resume_t1_addr", imem_addr, 32'h204);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_resume_pc", pc_out, 32'h200);
`else
        chk("mis_addr", imem_addr, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_flag_t1", 32'(fetch_misaligned), 32'h0);
        chk("mis_valid_t1", 32'(instr_valid), 32'h0);
        chk("mis_addr_t1", imem_addr, 32'h104);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_pc_t2", pc_out, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_pc_t3", pc_out, 32'h104);
`endif

        // Reset in the middle of streaming, then restart from the reset vector.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("midrst_valid", 32'(instr_valid), 32'h0);
        chk("midrst_instr", instr_out, 32'h0);
        chk("midrst_pc", pc_out, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_r0_addr", imem_addr, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_r1_valid", 32'(instr_valid), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_r2_valid", 32'(instr_valid), 32'h1);
        chk("midrst_r2_pc", pc_out, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_r3_pc", pc_out, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
